// File: rtl/maindec_mc_pkg.sv
// Shared types and encodings for the multicycle LEGv8 main decoder.
// The optional exception state is enabled by the macro MAINDEC_MC_EXC_EN.
package maindec_mc_pkg;

  localparam int OPCODE_W = 11;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, EXC
  } state_t;

  typedef enum logic [3:0] {
    LDUR, STUR, CBZ, CBNZ, B, RFMT, ADDI, SUBI, ILL
  } class_t;

  // Opcode patterns; '?' positions are don't-care in casez matching.
  localparam logic [OPCODE_W-1:0] OP_LDUR = 11'b11111000010;
  localparam logic [OPCODE_W-1:0] OP_STUR = 11'b11111000000;
  localparam logic [OPCODE_W-1:0] OP_CBZ  = 11'b10110100???;
  localparam logic [OPCODE_W-1:0] OP_CBNZ = 11'b10110101???;
  localparam logic [OPCODE_W-1:0] OP_B    = 11'b000101?????;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 11'b10001011000;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 11'b11001011000;
  localparam logic [OPCODE_W-1:0] OP_AND  = 11'b10001010000;
  localparam logic [OPCODE_W-1:0] OP_ORR  = 11'b10101010000;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 11'b1001000100?;
  localparam logic [OPCODE_W-1:0] OP_SUBI = 11'b1101000100?;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_PASS = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b11;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_EXC = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       branch;
    logic       br_nz;
    logic       reg2loc;
    logic       alu_src;
    logic       memto_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/maindec_mc_op_classify.sv
// Combinational opcode-to-class decoder, shared with the single-cycle path.
module op_classify
  import maindec_mc_pkg::*;
#(
  parameter int OP_W = OPCODE_W
) (
  input  logic [OP_W-1:0] op,
  output class_t          cls
);

  always_comb begin
    cls = ILL;
    casez (op)
      OP_LDUR: cls = LDUR;
      OP_STUR: cls = STUR;
      OP_CBZ:  cls = CBZ;
      OP_CBNZ: cls = CBNZ;
      OP_B:    cls = B;
      OP_ADD:  cls = RFMT;
      OP_SUB:  cls = RFMT;
      OP_AND:  cls = RFMT;
      OP_ORR:  cls = RFMT;
      OP_ADDI: cls = ADDI;
      OP_SUBI: cls = SUBI;
      default: cls = ILL;
    endcase
  end

endmodule

// File: rtl/maindec_mc.sv
// Multicycle LEGv8 control FSM with memory timeout and retire counter.
// Define MAINDEC_MC_EXC_EN to trap illegal opcodes through the EXC state.
module maindec_mc
  import maindec_mc_pkg::*;
#(
  parameter int OP_W    = 11,
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               Branch,
  output logic               BrNZ,
  output logic               Reg2Loc,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [CNT_W-1:0]   retired,
  output logic               mem_err
`ifdef MAINDEC_MC_EXC_EN
  ,
  output logic               exc,
  output logic [OP_W-1:0]    exc_op
`endif
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  class_t           cls_q, cls_d, op_cls;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_err_q, mem_err_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic             retire, timed_out;
  ctrl_t            ctrl, ctrl_o;
`ifdef MAINDEC_MC_EXC_EN
  logic [OP_W-1:0]  exc_op_q, exc_op_d;
  logic             exc_c;
`endif

  op_classify #(.OP_W(OP_W)) u_op_classify (
    .op  (Op),
    .cls (op_cls)
  );

  assign timed_out = (wait_q == WAIT_LIMIT) && !mem_ready;

  always_comb begin
    ctrl      = '0;
    state_d   = state_q;
    cls_d     = cls_q;
    mem_err_d = mem_err_q;
    wait_d    = '0;
    retire    = 1'b0;
`ifdef MAINDEC_MC_EXC_EN
    exc_op_d  = exc_op_q;
    exc_c     = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        if (timed_out) begin
          mem_err_d = 1'b1;
          state_d   = FETCH;
        end else begin
          ctrl.mem_req  = 1'b1;
          ctrl.mem_read = 1'b1;
          if (mem_ready) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PCSRC_PC4;
            state_d       = DECODE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      DECODE: begin
        ctrl.reg2loc = (op_cls == STUR) || (op_cls == CBZ) || (op_cls == CBNZ);
        cls_d        = op_cls;
        state_d      = EXEC;
      end
      EXEC: begin
        case (cls_q)
          RFMT: begin
            ctrl.alu_op = ALUOP_R;
            state_d     = WB;
          end
          ADDI, SUBI: begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALUOP_I;
            state_d      = WB;
          end
          LDUR, STUR: begin
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALUOP_ADD;
            state_d      = MEM;
          end
          CBZ, CBNZ: begin
            ctrl.branch = 1'b1;
            ctrl.br_nz  = (cls_q == CBNZ);
            ctrl.alu_op = ALUOP_PASS;
            ctrl.pc_src = PCSRC_BR;
            state_d     = FETCH;
            retire      = 1'b1;
          end
          B: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PCSRC_BR;
            state_d       = FETCH;
            retire        = 1'b1;
          end
          default: begin
`ifdef MAINDEC_MC_EXC_EN
            state_d  = EXC;
            exc_op_d = Op;
`else
            state_d  = FETCH;
`endif
          end
        endcase
      end
      MEM: begin
        if (timed_out) begin
          mem_err_d = 1'b1;
          state_d   = FETCH;
        end else begin
          ctrl.mem_req   = 1'b1;
          ctrl.iord      = 1'b1;
          ctrl.mem_read  = (cls_q == LDUR);
          ctrl.mem_write = (cls_q == STUR);
          if (mem_ready) begin
            if (cls_q == STUR) begin
              state_d = FETCH;
              retire  = 1'b1;
            end else begin
              state_d = WB;
            end
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = (cls_q == LDUR);
        state_d        = FETCH;
        retire         = 1'b1;
      end
      EXC: begin
`ifdef MAINDEC_MC_EXC_EN
        exc_c = 1'b1;
`endif
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_EXC;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
    retired_d = retire ? retired_q + 1'b1 : retired_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      cls_q     <= ILL;
      retired_q <= '0;
      mem_err_q <= 1'b0;
      wait_q    <= '0;
`ifdef MAINDEC_MC_EXC_EN
      exc_op_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
      mem_err_q <= mem_err_d;
      wait_q    <= wait_d;
`ifdef MAINDEC_MC_EXC_EN
      exc_op_q  <= exc_op_d;
`endif
    end
  end

  // Every output is silenced combinationally while reset is high.
  assign ctrl_o   = reset ? '0 : ctrl;
  assign mem_req  = ctrl_o.mem_req;
  assign IorD     = ctrl_o.iord;
  assign MemRead  = ctrl_o.mem_read;
  assign MemWrite = ctrl_o.mem_write;
  assign IRWrite  = ctrl_o.ir_write;
  assign PCWrite  = ctrl_o.pc_write;
  assign PCSrc    = ctrl_o.pc_src;
  assign Branch   = ctrl_o.branch;
  assign BrNZ     = ctrl_o.br_nz;
  assign Reg2Loc  = ctrl_o.reg2loc;
  assign ALUSrc   = ctrl_o.alu_src;
  assign MemtoReg = ctrl_o.memto_reg;
  assign RegWrite = ctrl_o.reg_write;
  assign ALUOp    = ctrl_o.alu_op;
  assign retired  = reset ? '0 : retired_q;
  assign mem_err  = reset ? 1'b0 : mem_err_q;
`ifdef MAINDEC_MC_EXC_EN
  assign exc      = reset ? 1'b0 : exc_c;
  assign exc_op   = reset ? '0 : exc_op_q;
`endif

endmodule

// File: tb/tb_maindec_mc.sv
// Randomized transaction-level bench for maindec_mc (optionally with MAINDEC_MC_EXC_EN).
module tb_maindec_mc;

  localparam int TIMEOUT = 16;

  // Control word bit positions, MSB first: mem_req IorD MemRead MemWrite IRWrite PCWrite
  // PCSrc[1:0] Branch BrNZ Reg2Loc ALUSrc MemtoReg RegWrite ALUOp[1:0]
  localparam logic [15:0] C_REQ  = 16'h8000, C_IORD = 16'h4000, C_RD  = 16'h2000;
  localparam logic [15:0] C_WR   = 16'h1000, C_IRW  = 16'h0800, C_PCW = 16'h0400;
  localparam logic [15:0] C_PCBR = 16'h0100, C_PCEX = 16'h0200, C_BR  = 16'h0080;
  localparam logic [15:0] C_NZ   = 16'h0040, C_R2L  = 16'h0020, C_ASRC = 16'h0010;
  localparam logic [15:0] C_M2R  = 16'h0008, C_RW   = 16'h0004;
  localparam logic [15:0] C_AOPP = 16'h0001, C_AOPR = 16'h0002, C_AOPI = 16'h0003;

  typedef enum {K_LDUR, K_STUR, K_CBZ, K_CBNZ, K_B, K_RFMT, K_ADDI, K_SUBI, K_ILL} kind_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] op = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0]  PCSrc, ALUOp;
  logic        Branch, BrNZ, Reg2Loc, ALUSrc, MemtoReg, RegWrite, mem_err;
  logic [31:0] retired;
`ifdef MAINDEC_MC_EXC_EN
  logic        exc;
  logic [10:0] exc_op;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_retired = 0;
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  maindec_mc #(.OP_W(11), .ALUOP_W(2), .CNT_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .Op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch),
    .BrNZ(BrNZ), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUOp(ALUOp), .retired(retired), .mem_err(mem_err)
`ifdef MAINDEC_MC_EXC_EN
    , .exc(exc), .exc_op(exc_op)
`endif
  );

  wire [15:0] obs_ctl = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc,
                         Branch, BrNZ, Reg2Loc, ALUSrc, MemtoReg, RegWrite, ALUOp};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive mem_ready, check the control word mid-cycle, advance to next cycle.
  task automatic cyc(input string tag, input bit rdy, input logic [15:0] exp);
    mem_ready = rdy;
    #4;
    check_eq(tag, {48'h0, obs_ctl}, {48'h0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_retired"}, {32'h0, retired}, {32'h0, 32'(exp_retired)});
    check_eq({tag, "_mem_err"}, {63'h0, mem_err}, {63'h0, exp_err});
  endtask

  function automatic logic [10:0] make_op(input kind_t k);
    logic [10:0] r;
    logic [10:0] ill_tab [5];
    ill_tab = '{11'h000, 11'h7FF, 11'b10001011001, 11'b11111000011, 11'b10110110000};
    r = 11'($urandom);
    case (k)
      K_LDUR: return 11'b11111000010;
      K_STUR: return 11'b11111000000;
      K_CBZ:  return {8'b10110100, r[2:0]};
      K_CBNZ: return {8'b10110101, r[2:0]};
      K_B:    return {6'b000101, r[4:0]};
      K_RFMT: case (r[1:0])
                2'd0:    return 11'b10001011000;
                2'd1:    return 11'b11001011000;
                2'd2:    return 11'b10001010000;
                default: return 11'b10101010000;
              endcase
      K_ADDI: return {10'b1001000100, r[0]};
      K_SUBI: return {10'b1101000100, r[0]};
      default: return ill_tab[$urandom_range(0, 4)];
    endcase
  endfunction

  // Memory wait phase; returns 1 if the request timed out.
  task automatic mem_phase(input string tag, input int waits, input logic [15:0] base,
                           input logic [15:0] done, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < waits && i < TIMEOUT - 1; i++) cyc({tag, "_wait"}, 1'b0, base);
    if (waits >= TIMEOUT) begin
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      exp_err = 1'b1;
      aborted = 1'b1;
    end else begin
      cyc(tag, 1'b1, base | done);
    end
  endtask

  // Runs one instruction through the DUT and checks every cycle against the class rules.
  task automatic run_instr(input kind_t k, input logic [10:0] opc, input int fw, input int mw);
    bit ab;
    op = 11'($urandom);
    mem_phase("fetch", fw, C_REQ | C_RD, C_IRW | C_PCW, ab);
    if (ab) begin
      check_status("fetch_to");
      return;
    end
    op = opc;
    cyc("decode", 1'($urandom), (k == K_STUR || k == K_CBZ || k == K_CBNZ) ? C_R2L : 16'h0);
    case (k)
      K_RFMT: begin
        cyc("exec_r", 1'($urandom), C_AOPR);
        cyc("wb_r", 1'($urandom), C_RW);
        exp_retired++;
      end
      K_ADDI, K_SUBI: begin
        cyc("exec_i", 1'($urandom), C_ASRC | C_AOPI);
        cyc("wb_i", 1'($urandom), C_RW);
        exp_retired++;
      end
      K_LDUR, K_STUR: begin
        cyc("exec_ls", 1'($urandom), C_ASRC);
        mem_phase("mem", mw, C_REQ | C_IORD | ((k == K_LDUR) ? C_RD : C_WR), 16'h0, ab);
        if (!ab) begin
          if (k == K_LDUR) cyc("wb_ld", 1'($urandom), C_RW | C_M2R);
          exp_retired++;
        end
      end
      K_CBZ:  begin cyc("exec_cbz", 1'($urandom), C_BR | C_AOPP | C_PCBR); exp_retired++; end
      K_CBNZ: begin cyc("exec_cbnz", 1'($urandom), C_BR | C_NZ | C_AOPP | C_PCBR); exp_retired++; end
      K_B:    begin cyc("exec_b", 1'($urandom), C_PCW | C_PCBR); exp_retired++; end
      default: begin
        cyc("exec_ill", 1'($urandom), 16'h0);
`ifdef MAINDEC_MC_EXC_EN
        mem_ready = 1'($urandom);
        #4;
        check_eq("exc_pulse", {63'h0, exc}, 64'h1);
        check_eq("exc_op", {53'h0, exc_op}, {53'h0, opc});
        check_eq("exc_ctl", {48'h0, obs_ctl}, {48'h0, C_PCW | C_PCEX});
        @(posedge clk);
        #1;
        #4;
        check_eq("exc_drop", {63'h0, exc}, 64'h0);
        #1;
`endif
      end
    endcase
    check_status("instr");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kind_t k;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      op = 11'($urandom);
      cyc("reset_ctl", 1'($urandom), 16'h0);
    end
    check_status("reset");
    reset = 1'b0;

    // Directed cases from the plan.
    run_instr(K_RFMT, 11'b10001011000, 0, 0);
    run_instr(K_LDUR, 11'b11111000010, 0, 3);
    run_instr(K_CBNZ, 11'b10110101011, 0, 0);
    run_instr(K_B,    11'b00010100000, 0, 0);
    run_instr(K_ILL,  11'b00000000000, 0, 0);
    run_instr(K_ADDI, make_op(K_ADDI), TIMEOUT - 1, 0);
    run_instr(K_STUR, make_op(K_STUR), 2, TIMEOUT - 1);

    for (int n = 0; n < 150; n++) begin
      k = kind_t'($urandom_range(0, 8));
      run_instr(k, make_op(k), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0,
                $urandom_range(0, 4));
    end

    // Timeouts in FETCH and in MEM, then mem_err must stay set.
    run_instr(K_RFMT, make_op(K_RFMT), TIMEOUT, 0);
    run_instr(K_SUBI, make_op(K_SUBI), 0, 0);
    run_instr(K_LDUR, make_op(K_LDUR), 1, TIMEOUT);
    for (int n = 0; n < 20; n++) begin
      k = kind_t'($urandom_range(0, 8));
      run_instr(k, make_op(k), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the MEM cycle of a STUR aborts it with no strobe.
    op = 11'($urandom);
    cyc("rst_fetch", 1'b1, C_REQ | C_RD | C_IRW | C_PCW);
    op = 11'b11111000000;
    cyc("rst_decode", 1'b0, C_R2L);
    cyc("rst_exec", 1'b0, C_ASRC);
    reset = 1'b1;
    exp_retired = 0;
    exp_err = 1'b0;
    cyc("rst_mem_ctl", 1'b1, 16'h0);
    check_status("rst_mem");
    reset = 1'b0;
    run_instr(K_RFMT, make_op(K_RFMT), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maindec_mc.md
Name: maindec_mc

Overview:
- Multicycle LEGv8 control unit; next generation of the single-cycle main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a ready handshake.
- Adds I-format (ADDI/SUBI), CBNZ and unconditional B to LDUR/STUR/CBZ/R-format, plus a retired-instruction counter and a memory timeout.
- Sits between the IR and the multicycle datapath (PC, IR, register file, ALU, unified memory).

Parameters:
- OP_W, 11, opcode field width (IR[31:21]).
- ALUOP_W, 2, ALUOp width to alu decoder.
- CNT_W, 32, retired-instruction counter width.
- TIMEOUT, 16, max cycles waiting for mem_ready before abort; must be >=2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Op  in  OP_W  opcode from IR; valid from DECODE until the instruction retires.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  0 = PC address (fetch), 1 = ALU result address.
- MemRead, MemWrite  out  1  memory direction.
- IRWrite  out  1  load IR.
- PCWrite  out  1  unconditional PC load.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = exception vector.
- Branch  out  1  conditional PC load when ALU zero matches BrNZ.
- BrNZ  out  1  0 = CBZ sense, 1 = CBNZ sense.
- Reg2Loc, ALUSrc, MemtoReg, RegWrite  out  1  same meaning as in single-cycle control.
- ALUOp  out  ALUOP_W  00 = add, 01 = pass B / compare, 10 = R-type funct, 11 = I-type add/sub.
- retired  out  CNT_W  count of completed instructions.
- mem_err  out  1  sticky: a memory request timed out.

Behaviour:
- All outputs are decoded from registered state plus the class register cls_q. They are forced to 0 while reset is high.
- Reset effects: state <= FETCH, cls_q <= ILL, retired <= 0, mem_err <= 0, wait counter <= 0.
- Decode classes from Op, latched into cls_q in DECODE:
  - LDUR 11111000010
  - STUR 11111000000
  - CBZ 10110100???
  - CBNZ 10110101???
  - B 000101?????
  - RFMT: exactly 10001011000, 11001011000, 10001010000, 10101010000
  - ADDI 1001000100?
  - SUBI 1101000100?
  - anything else is ILL
- FETCH: mem_req=1, IorD=0, MemRead=1. Hold until mem_ready. In the mem_ready cycle: IRWrite=1, PCWrite=1, PCSrc=00, then go to DECODE.
- DECODE: Reg2Loc=1 for STUR/CBZ/CBNZ, else 0. Latch cls_q. Go to EXEC.
- EXEC:
  - RFMT: ALUOp=10 -> WB.
  - ADDI/SUBI: ALUSrc=1, ALUOp=11 -> WB.
  - LDUR/STUR: ALUSrc=1, ALUOp=00 -> MEM.
  - CBZ/CBNZ: Branch=1, BrNZ=(CBNZ), ALUOp=01, PCSrc=01 -> FETCH, retire.
  - B: PCWrite=1, PCSrc=01 -> FETCH, retire.
  - ILL: no write strobes -> FETCH, no retire (see the optional feature for the alternative).
- MEM: mem_req=1, IorD=1. MemRead=1 for LDUR, MemWrite=1 for STUR. Held stable until mem_ready. On mem_ready: STUR -> FETCH and retire; LDUR -> WB.
- WB: RegWrite=1, MemtoReg=(LDUR) -> FETCH, retire.
- Retire means retired increments by 1 on the transition edge. It wraps modulo 2^CNT_W.
- Latency with zero-wait memory: R/I = 4 cycles, LDUR = 5, STUR = 4, CB*/B = 3.
- Timeout:
  - The wait counter resets to 0 on entry to FETCH or MEM and increments each cycle in that state without mem_ready.
  - When the counter reaches TIMEOUT-1 and mem_ready is still low: set mem_err, drop the request, go to FETCH, no retire, no register write.
  - mem_ready in the same cycle as the limit wins (normal completion).
- Reset asserted mid-instruction aborts it in the same cycle: no strobe is issued and nothing retires.

Optional Feature:
- Macro MAINDEC_MC_EXC_EN.
- When defined, ILL in EXEC goes to state EXC instead of FETCH. EXC is one cycle: exc=1, PCWrite=1, PCSrc=10, then FETCH, no retire.
- When defined, extra output exc (1 bit) and exc_op (OP_W bits), which captures Op on entry to EXC and holds until the next EXC or reset (reset value 0).
- Without the macro: ILL is a silent NOP, and ports exc/exc_op do not exist.

Decomposition:
- Package maindec_mc_pkg holds:
  - state_t enum FETCH, DECODE, EXEC, MEM, WB, EXC
  - class_t enum LDUR, STUR, CBZ, CBNZ, B, RFMT, ADDI, SUBI, ILL
  - opcode pattern constants
  - ALUOp and PCSrc encodings
- One natural sub-module, op_classify: a purely combinational Op -> class_t decoder using casez, reusable by the single-cycle path.

Test Plan:
- Zero-wait ADD (Op=10001011000): FETCH, DECODE, EXEC, WB in 4 cycles. ALUOp=10 in EXEC, RegWrite=1 only in WB, retired 0->1.
- LDUR with mem_ready delayed 3 cycles in MEM: MemRead/IorD=1 held for 4 cycles, then WB with MemtoReg=1. Total 8 cycles, retired +1.
- CBNZ (10110101011) then B (00010100000): Branch=1, BrNZ=1 in EXEC; then PCWrite=1, PCSrc=01. Each takes 3 cycles, retired +2.
- mem_ready held low in FETCH with TIMEOUT=16: after 16 cycles mem_err=1, state back to FETCH, retired unchanged, mem_err stays set until reset.
- Op=00000000000 without the macro: NOP, no write strobes, retired unchanged. With MAINDEC_MC_EXC_EN: exc pulses for 1 cycle, PCSrc=10, exc_op=0.
- reset asserted in MEM of a STUR: MemWrite=0 that cycle, next state FETCH, retired=0, all outputs 0 during reset.
